// File: rtl/av2_recon_adder.sv
// rtl/av2_recon_adder.sv - AV2 reconstruction adder: prediction + residual, clipped, two-stage pipeline
module av2_recon_adder #(
    parameter int PIX_PER_BEAT = 4,
    parameter int RES_W        = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [15:0]                frame_width,
    input  logic [15:0]                frame_height,
    input  logic [3:0]                 bit_depth,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PIX_PER_BEAT*10-1:0] pred_data,
    input  logic [PIX_PER_BEAT*RES_W-1:0] res_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PIX_PER_BEAT*10-1:0] out_data,
    output logic [15:0]                out_x,
    output logic [15:0]                out_y,
    output logic                       out_last,
    output logic                       busy,
    output logic                       done,
    output logic                       cfg_err
);

    localparam int SUM_W = RES_W + 2;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t state, state_nxt;

    logic [15:0] width_q, height_q, in_x, in_y;
    logic [9:0]  max_q;

    logic                                s1_valid;
    logic [PIX_PER_BEAT-1:0][SUM_W-1:0]  s1_sum;
    logic [15:0]                         s1_x, s1_y;
    logic                                s1_last;

    logic [PIX_PER_BEAT-1:0][SUM_W-1:0]  in_sum;
    logic [PIX_PER_BEAT*10-1:0]          clip_data;

    logic cfg_ok, start_ok, advance, accept, in_last, out_fire_last;

    assign cfg_ok   = (frame_width != 16'd0) && (frame_height != 16'd0) &&
                      ((frame_width % 16'(PIX_PER_BEAT)) == 16'd0);
    assign start_ok = (state == IDLE) && start && cfg_ok;

    // Stage 2 frees up when empty or draining; stage 1 moves in lockstep with it.
    assign advance  = !out_valid || out_ready;
    assign in_ready = (state == RUN) && (!s1_valid || advance);
    assign accept   = in_valid && in_ready;
    assign in_last  = (({1'b0, in_x} + 17'(PIX_PER_BEAT)) == {1'b0, width_q}) &&
                      (in_y == height_q - 16'd1);
    assign out_fire_last = out_valid && out_ready && out_last;
    assign busy     = (state != IDLE);

    always_comb begin
        in_sum    = '0;
        clip_data = '0;
        for (int k = 0; k < PIX_PER_BEAT; k++) begin
            in_sum[k] = {{(SUM_W-10){1'b0}}, pred_data[10*k +: 10]} +
                        {{2{res_data[RES_W*k+RES_W-1]}}, res_data[RES_W*k +: RES_W]};
            if (s1_sum[k][SUM_W-1])
                clip_data[10*k +: 10] = 10'd0;
            else if (s1_sum[k] > {{(SUM_W-10){1'b0}}, max_q})
                clip_data[10*k +: 10] = max_q;
            else
                clip_data[10*k +: 10] = s1_sum[k][9:0];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = RUN;
            RUN:     if (accept && in_last) state_nxt = DRAIN;
            DRAIN:   if (out_fire_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            width_q   <= '0;
            height_q  <= '0;
            max_q     <= '0;
            in_x      <= '0;
            in_y      <= '0;
            s1_valid  <= 1'b0;
            s1_sum    <= '0;
            s1_x      <= '0;
            s1_y      <= '0;
            s1_last   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_x     <= '0;
            out_y     <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            state   <= state_nxt;
            done    <= (state == DRAIN) && out_fire_last;
            cfg_err <= (state == IDLE) && start && !cfg_ok;

            if (start_ok) begin
                width_q  <= frame_width;
                height_q <= frame_height;
                max_q    <= (bit_depth == 4'd8) ? 10'd255 : 10'd1023;
                in_x     <= '0;
                in_y     <= '0;
            end

            if (accept) begin
                s1_valid <= 1'b1;
                s1_sum   <= in_sum;
                s1_x     <= in_x;
                s1_y     <= in_y;
                s1_last  <= in_last;
                if (({1'b0, in_x} + 17'(PIX_PER_BEAT)) == {1'b0, width_q}) begin
                    in_x <= '0;
                    in_y <= in_y + 16'd1;
                end else begin
                    in_x <= in_x + 16'(PIX_PER_BEAT);
                end
            end else if (advance) begin
                s1_valid <= 1'b0;
            end

            if (advance) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_data <= clip_data;
                    out_x    <= s1_x;
                    out_y    <= s1_y;
                    out_last <= s1_last;
                end
            end
        end
    end

endmodule
